// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per cycle, LSB first, with a done pulse.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d;
  logic             br_next;

  always_comb begin
    d       = areg[0] ^ breg[0] ^ br;
    br_next = (~areg[0] & breg[0]) | (~(areg[0] ^ breg[0]) & br);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      areg  <= '0;
      breg  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
      ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            areg  <= a;
            breg  <= b;
            br    <= 1'b0;
            cnt   <= '0;
            bout  <= 1'b0;
            ready <= 1'b0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
          diff <= {d, diff[WIDTH-1:1]};
          areg <= areg >> 1;
          breg <= breg >> 1;
          br   <= br_next;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            bout  <= br_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic amsb;
  logic bmsb;

  // Operand sign bits are captured at start; the final d is the result sign bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      amsb <= 1'b0;
      bmsb <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        amsb <= a[WIDTH-1];
        bmsb <= b[WIDTH-1];
        ovf  <= 1'b0;
      end else if (state == SHIFT && cnt == LAST) begin
        ovf <= (amsb != bmsb) & (d != amsb);
      end
    end
  end
`endif

endmodule
